clk_ctrl_gen: RTL and testbench

Parametrised clock and clock-enable generator for the CPU/GPIO lab top level. It provides:
- a free-running divider counter;
- a CPU clock with four selectable modes: fast, slow tap, debounced single-step and hold;
- NCH independently programmable clock-enable strobes for peripherals.

It replaces the fixed fast/slow divider. Mode switching is glitch-free, and each step-button press produces exactly one CPU clock pulse.

---
 rtl/clk_ctrl_gen.sv | 176 +++++++++++++++++
 tb/tb_clk_ctrl_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_ctrl_gen.sv
// clk_ctrl_gen: free-running divider, glitch-free CPU clock mode mux with
// debounced single-step, and per-channel programmable clock-enable strobes.
module clk_ctrl_gen #(
   parameter int CNT_W     = 32,
   parameter int SLOW_TAP  = 24,
   parameter int DB_CYCLES = 1_000_000,
   parameter int STEP_HI   = 4,
   parameter int NCH       = 4,
   parameter int DIV_W     = 16,
   parameter int DIV_INIT  = 0,
   localparam int SEL_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic             STEP,
   input  logic             div_we,
   input  logic [SEL_W-1:0] div_sel,
   input  logic [DIV_W-1:0] div_val,
   output logic [CNT_W-1:0] clkdiv,
   output logic             CPUClk,
   output logic             nCPUClk,
   output logic [NCH-1:0]   ce,
   output logic             step_busy
);

   typedef enum logic [1:0] {
      M_FAST = 2'b00,
      M_SLOW = 2'b01,
      M_STEP = 2'b10,
      M_HOLD = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HIGH,
      S_WAIT
   } step_t;

   localparam int DBC_W = $clog2(DB_CYCLES + 1);
   localparam int HI_W  = $clog2(STEP_HI + 1);

   mode_t            act_mode;
   step_t            state;
   step_t            state_nx;
   logic             sync1;
   logic             sync2;
   logic             db;
   logic             db_q;
   logic [DBC_W-1:0] db_cnt;
   logic [HI_W-1:0]  hi_cnt;
   logic [HI_W-1:0]  hi_cnt_nx;
   logic             cpu_nx;
   logic             busy_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) clkdiv <= '0;
      else     clkdiv <= clkdiv + CNT_W'(1);
   end

   // Any disagreement that does not persist restarts the stability count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         db     <= 1'b0;
         db_q   <= 1'b0;
         db_cnt <= '0;
      end else begin
         sync1 <= STEP;
         sync2 <= sync1;
         db_q  <= db;
         if (sync2 == db) begin
            db_cnt <= '0;
         end else if (db_cnt == DBC_W'(DB_CYCLES - 1)) begin
            db     <= sync2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DBC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                           act_mode <= M_FAST;
      else if (!CPUClk && state == S_IDLE) act_mode <= mode_t'(mode);
   end

   always_comb begin
      state_nx  = state;
      hi_cnt_nx = hi_cnt;
      cpu_nx    = 1'b0;
      busy_nx   = 1'b0;
      if (act_mode != M_STEP) begin
         state_nx = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (db && !db_q) begin
                  state_nx  = S_HIGH;
                  hi_cnt_nx = HI_W'(STEP_HI - 1);
               end
            end
            S_HIGH: begin
               if (hi_cnt == '0) state_nx = S_WAIT;
               else              hi_cnt_nx = hi_cnt - HI_W'(1);
            end
            S_WAIT: begin
               if (!db) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
         endcase
      end
      unique case (act_mode)
         M_FAST:  cpu_nx = ~CPUClk;
         M_SLOW:  cpu_nx = clkdiv[SLOW_TAP];
         M_STEP:  cpu_nx = (state_nx == S_HIGH);
         default: cpu_nx = 1'b0;
      endcase
      busy_nx = (state_nx != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         hi_cnt    <= '0;
         CPUClk    <= 1'b0;
         step_busy <= 1'b0;
      end else begin
         state     <= state_nx;
         hi_cnt    <= hi_cnt_nx;
         CPUClk    <= cpu_nx;
         step_busy <= busy_nx;
      end
   end

   assign nCPUClk = ~CPUClk;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic             wr;
      logic [DIV_W-1:0] div_r;
      logic [DIV_W-1:0] cnt_r;
      logic [DIV_W-1:0] div_nx;
      logic [DIV_W-1:0] cnt_nx;
      logic             ce_r;

      // Selects at or beyond NCH never match any channel
      assign wr = div_we && (32'(div_sel) == i);

      always_comb begin
         div_nx = div_r;
         cnt_nx = '0;
         if (wr) begin
            div_nx = div_val;
            cnt_nx = '0;
         end else if (cnt_r != div_r) begin
            cnt_nx = cnt_r + DIV_W'(1);
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            div_r <= DIV_W'(DIV_INIT);
            cnt_r <= '0;
            ce_r  <= 1'b0;
         end else begin
            div_r <= div_nx;
            cnt_r <= cnt_nx;
            ce_r  <= (cnt_nx == div_nx);
         end
      end

      assign ce[i] = ce_r;
   end

endmodule

// File: tb/tb_clk_ctrl_gen.sv
// tb_clk_ctrl_gen: directed stimulus pushes expected samples into a queue;
// a negedge monitor pops and compares them against the design outputs.
module tb_clk_ctrl_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  mode = 2'b00;
   logic        step = 1'b0;
   logic        div_we = 1'b0;
   logic [1:0]  div_sel = 2'd0;
   logic [15:0] div_val = 16'd0;
   logic [7:0]  clkdiv;
   logic        cpu_clk;
   logic        n_cpu_clk;
   logic [3:0]  ce;
   logic        step_busy;

   int cyc = 0;
   int tests = 0;
   int fails = 0;
   int c0 = 0;

   typedef struct {
      int          cyc;
      int          sig;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t q[$];

   clk_ctrl_gen #(
      .CNT_W(8),
      .SLOW_TAP(3),
      .DB_CYCLES(8),
      .STEP_HI(4),
      .NCH(4),
      .DIV_W(16),
      .DIV_INIT(0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mode(mode),
      .STEP(step),
      .div_we(div_we),
      .div_sel(div_sel),
      .div_val(div_val),
      .clkdiv(clkdiv),
      .CPUClk(cpu_clk),
      .nCPUClk(n_cpu_clk),
      .ce(ce),
      .step_busy(step_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] sample(int s);
      case (s)
         0:       return 32'(clkdiv);
         1:       return 32'(cpu_clk);
         2:       return 32'(n_cpu_clk);
         3:       return 32'(ce);
         4:       return 32'(step_busy);
         default: return 32'(ce[s-10]);
      endcase
   endfunction

   always @(negedge clk) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
         logic [31:0] a;
         if (q[i].cyc < cyc) begin
            tests++;
            fails++;
            $display("FAIL %s: missed, due cycle %0d now %0d",
                     q[i].name, q[i].cyc, cyc);
            q.delete(i);
         end else if (q[i].cyc == cyc) begin
            a = sample(q[i].sig);
            tests++;
            if (a !== q[i].val) begin
               fails++;
               $display("FAIL %s: got %0h expected %0h at cycle %0d",
                        q[i].name, a, q[i].val, cyc);
            end
            q.delete(i);
         end
      end
   end

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_at(int d, int s, logic [31:0] v, string nm);
      exp_t e;
      e.cyc  = cyc + d;
      e.sig  = s;
      e.val  = v;
      e.name = nm;
      q.push_back(e);
   endtask

   int dexp[12] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 1};

   initial begin
      // reset values, clkdiv frozen while rst held
      tick(2);
      exp_at(0, 0, 32'd0, "rst_clkdiv");
      exp_at(0, 1, 32'd0, "rst_cpuclk");
      exp_at(0, 2, 32'd1, "rst_ncpuclk");
      exp_at(0, 3, 32'd0, "rst_ce");
      exp_at(0, 4, 32'd0, "rst_busy");
      exp_at(1, 0, 32'd0, "rst_clkdiv_hold");
      tick(1);
      rst = 1'b0;
      c0 = cyc;
      for (int d = 1; d <= 10; d++) begin
         exp_at(d, 0, 32'(d), "fast_clkdiv");
         exp_at(d, 1, 32'(d % 2), "fast_cpuclk");
      end
      exp_at(1, 2, 32'd0, "fast_ncpuclk");
      exp_at(1, 3, 32'hF, "init_ce");
      tick(12);

      // channel divisors 0/1/3/255
      div_we = 1'b1;
      div_sel = 2'd0;
      div_val = 16'd0;
      for (int k = 0; k < 12; k++) exp_at(1 + k, 10, 32'd1, "ce0_div0");
      tick(1);
      div_sel = 2'd1;
      div_val = 16'd1;
      for (int k = 0; k < 30; k++)
         exp_at(1 + k, 11, 32'(k % 2 == 1), "ce1_div1");
      tick(1);
      div_sel = 2'd2;
      div_val = 16'd3;
      for (int k = 0; k < 6; k++)
         exp_at(1 + k, 12, 32'(k % 4 == 3), "ce2_div3");
      tick(1);
      div_sel = 2'd3;
      div_val = 16'd255;
      exp_at(1, 13, 32'd0, "ce3_start");
      exp_at(255, 13, 32'd0, "ce3_before");
      exp_at(256, 13, 32'd1, "ce3_period");
      exp_at(257, 13, 32'd0, "ce3_after");
      tick(1);
      div_we = 1'b0;
      tick(4);

      // rewrite channel 2 mid-count
      div_we = 1'b1;
      div_sel = 2'd2;
      div_val = 16'd5;
      for (int k = 0; k < 13; k++)
         exp_at(1 + k, 12, 32'(k % 6 == 5), "ce2_rewrite");
      tick(1);
      div_we = 1'b0;
      tick(260);

      // slow mode across a clkdiv wrap
      mode = 2'b01;
      tick(4);
      for (int b = 0; b < 300 && (((cyc - c0) & 255) != 240); b++) tick(1);
      for (int d = 0; d < 48; d++) begin
         exp_at(d, 1, 32'(((cyc + d - c0 - 1) >> 3) & 1), "slow_cpuclk");
         exp_at(d, 0, 32'((cyc + d - c0) & 255), "slow_clkdiv");
      end
      tick(48);

      // slow -> fast requested right after CPUClk rises
      for (int b = 0; b < 40 && (((cyc - c0 - 1) & 15) != 8); b++) tick(1);
      mode = 2'b00;
      for (int i = 0; i < 12; i++)
         exp_at(i + 1, 1, 32'(dexp[i]), "defer_cpuclk");
      tick(13);

      // step mode with bounce on press and release
      mode = 2'b10;
      tick(4);
      exp_at(0, 1, 32'd0, "step_idle_cpuclk");
      exp_at(0, 4, 32'd0, "step_idle_busy");
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(1);
      step = 1'b1;
      for (int d = 0; d <= 40; d++) begin
         exp_at(d, 1, 32'(d >= 11 && d <= 14), "step_cpuclk");
         exp_at(d, 4, 32'(d >= 11), "step_busy_hold");
      end
      tick(40);
      step = 1'b0;
      for (int d = 1; d <= 16; d++) begin
         exp_at(d, 1, 32'd0, "step_rel_cpuclk");
         exp_at(d, 4, 32'(d <= 12), "step_busy_rel");
      end
      tick(1);
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(15);

      // hold mode ignores the step button
      mode = 2'b11;
      step = 1'b1;
      for (int d = 1; d <= 20; d++) begin
         exp_at(d, 1, 32'd0, "hold_cpuclk");
         exp_at(d, 4, 32'd0, "hold_busy");
      end
      tick(10);
      step = 1'b0;
      tick(10);

      // reset during the step high phase
      mode = 2'b10;
      tick(3);
      step = 1'b1;
      exp_at(10, 1, 32'd0, "rstep_pre");
      exp_at(11, 1, 32'd1, "rstep_high");
      exp_at(11, 4, 32'd1, "rstep_busy");
      tick(12);
      exp_at(0, 1, 32'd0, "rst_mid_cpuclk");
      exp_at(0, 4, 32'd0, "rst_mid_busy");
      exp_at(0, 0, 32'd0, "rst_mid_clkdiv");
      exp_at(0, 2, 32'd1, "rst_mid_ncpuclk");
      exp_at(0, 3, 32'd0, "rst_mid_ce");
      rst = 1'b1;
      step = 1'b0;
      mode = 2'b00;
      tick(2);
      rst = 1'b0;
      c0 = cyc;
      for (int d = 1; d <= 5; d++) exp_at(d, 0, 32'(d), "restart_clkdiv");
      exp_at(1, 3, 32'hF, "restart_ce");
      exp_at(1, 1, 32'd1, "restart_cpuclk1");
      exp_at(2, 1, 32'd0, "restart_cpuclk2");
      tick(8);

      for (int b = 0; b < 50 && q.size() > 0; b++) tick(1);
      if (q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d checks pending, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
